// File: rtl/sram_sp_master_pkg.sv
// Shared types and helpers for the single-port SRAM master.
//   state_e      : controller state (zero-fill after reset, then normal operation)
//   rsp_entry_t  : one response queue entry (error flag + read data)
//   clog2        : ceiling log2 usable in parameter expressions
package sram_sp_master_pkg;

  // Widest supported data bus; narrower buses use the low bits of rsp_entry_t.data.
  localparam int unsigned MaxDw = 32;
  localparam int unsigned RspFifoDepth = 3;

  typedef enum logic {
    StClear,
    StRun
  } state_e;

  typedef struct packed {
    logic             err;
    logic [MaxDw-1:0] data;
  } rsp_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_sp_master_if.sv
// Request/response bus of the SRAM master.
//   master : issues requests (valid/we/addr/data/sel), consumes responses (rsp_ready)
//   slave  : accepts requests (req_ready), produces responses (valid/data/err)
interface sram_sp_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_data, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small circular response FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write an entry (never issued when full)
//   pop/dout : read/remove the head entry (never issued when empty)
//   empty    : no entries held
//   count    : number of entries held
module sram_rsp_fifo
  import sram_sp_master_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned PtrW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int unsigned CntW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      // Push and pop together leave the count unchanged.
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: the head is only consumed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_sp_master.sv
// Single-port SRAM master: zero-fills the SRAM after reset, then turns bus requests into
// SRAM accesses and returns one in-order response per request through a 3-entry FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : request/response bus (slave side)
//   sram_ce/we/oe, sram_waddr, sram_din, sram_sel : SRAM port controls, word address, data
//   sram_dout    : SRAM read data, valid the cycle after a read access
//   clear_done   : zero-fill finished (tied high when CLEAR_ON_RESET=0)
module sram_sp_master
  import sram_sp_master_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned MEM_SIZE_BYTE = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int unsigned SW = DW / 8,
  localparam int unsigned WORD_AW = AW - clog2(SW)
) (
  input  logic               clk,
  input  logic               rst,
  sram_sp_master_if.slave    bus,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [DW-1:0]      sram_dout,
  output logic               clear_done
);

  localparam int unsigned AlignW = clog2(SW);
  localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW;
  localparam int unsigned ClrW = (MEM_SIZE_WORDS > 1) ? clog2(MEM_SIZE_WORDS) : 1;
  localparam int unsigned CntW = clog2(RspFifoDepth + 1);

  state_e          state_q;
  logic [ClrW-1:0] clr_cnt_q;
  logic            clear_done_q;

  logic            stage_valid_q, stage_err_q, stage_rd_q;

  logic [AW-1:0]   word_addr;
  logic            req_err, accept;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_pop;
  logic [DW:0]     fifo_din, fifo_dout;
  rsp_entry_t      push_entry, head_entry;

  // Request decode: misaligned or beyond the attached memory is an error and never hits SRAM.
  assign word_addr = bus.req_addr >> AlignW;
  assign req_err   = ((bus.req_addr & AW'(SW - 1)) != '0) ||
                     (word_addr >= AW'(MEM_SIZE_WORDS));

  // Stage + FIFO together never hold more than the FIFO depth, so a push never meets a full FIFO.
  assign bus.req_ready = !rst && (state_q == StRun) &&
                         ((3'(fifo_count) + 3'(stage_valid_q)) < 3'(RspFifoDepth));
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StRun;
      clr_cnt_q    <= '0;
      clear_done_q <= !CLEAR_ON_RESET;
    end else begin
      case (state_q)
        StClear: begin
          if (clr_cnt_q == ClrW'(MEM_SIZE_WORDS - 1)) begin
            state_q      <= StRun;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign clear_done = clear_done_q;

  // SRAM port: zero-fill writes while clearing, otherwise the accepted request itself.
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = '0;
    if (!rst && state_q == StClear) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_waddr = WORD_AW'(clr_cnt_q);
      sram_sel   = '1;
    end else if (accept && !req_err) begin
      sram_ce    = 1'b1;
      sram_we    = bus.req_we;
      sram_oe    = !bus.req_we;
      sram_waddr = word_addr[WORD_AW-1:0];
      sram_din   = bus.req_data;
      sram_sel   = bus.req_sel;
    end
  end

  // One stage lines the request up with sram_dout, which arrives a cycle after the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_err_q   <= 1'b0;
      stage_rd_q    <= 1'b0;
    end else begin
      stage_valid_q <= accept;
      stage_err_q   <= accept && req_err;
      stage_rd_q    <= accept && !req_err && !bus.req_we;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.err  = stage_err_q;
    push_entry.data = stage_rd_q ? MaxDw'(sram_dout) : '0;
    fifo_din        = {push_entry.err, push_entry.data[DW-1:0]};
  end

  sram_rsp_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (RspFifoDepth)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid_q),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    head_entry      = '0;
    head_entry.err  = fifo_dout[DW];
    head_entry.data = MaxDw'(fifo_dout[DW-1:0]);
  end

  // Outputs forced to zero while empty so stale storage never shows on the bus.
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_err   = !fifo_empty && head_entry.err;
  assign bus.rsp_data  = fifo_empty ? '0 : head_entry.data[DW-1:0];
  assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;

endmodule

// File: tb/tb_sram_sp_master.sv
// Bench for sram_sp_master (DW=32, 64-byte SRAM, zero-fill on reset). A behavioural SRAM
// sits on the port; a byte-array reference memory and an expected-response queue predict
// every response, the SRAM port activity and the ready/valid timing.
module tb_sram_sp_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MemBytes = 64;
  localparam int unsigned Words = MemBytes / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_sp_master_if #(.AW(AW), .DW(DW)) bus ();

  logic        sram_ce, sram_we, sram_oe, clear_done;
  logic [29:0] sram_waddr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;
  logic [3:0]  sram_sel;

  sram_sp_master #(
    .AW             (AW),
    .DW             (DW),
    .MEM_SIZE_BYTE  (MemBytes),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_waddr (sram_waddr),
    .sram_din   (sram_din),
    .sram_sel   (sram_sel),
    .sram_dout  (sram_dout),
    .clear_done (clear_done)
  );

  // Behavioural SRAM: byte-masked write, read data one cycle after the access.
  logic [31:0] sram_mem [Words];
  always @(posedge clk) begin
    if (sram_ce && sram_waddr < 30'(Words)) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_sel[b]) sram_mem[sram_waddr[3:0]][8*b +: 8] <= sram_din[8*b +: 8];
      end
      if (sram_oe) sram_dout <= sram_mem[sram_waddr[3:0]];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cnt = 0;
  bit   run_phase = 0;
  bit   rand_rdy  = 0;

  logic [7:0] ref_mem [MemBytes];
  exp_t       exp_q [$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor/scoreboard, sampling mid-cycle.
  logic [31:0] m_a;
  logic        m_err;
  logic [68:0] m_sram;
  exp_t        m_e;
  logic        hold_q = 1'b0;
  logic        hold_err;
  logic [31:0] hold_data;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      hold_q = 1'b0;
    end else if (run_phase) begin
      // Every outstanding request sits in the stage or the FIFO; at most 3 may be outstanding.
      check("req_ready", bus.req_ready, exp_q.size() < 3);
      if (exp_q.size() > 0) check("rsp_valid", bus.rsp_valid, (cyc - exp_q[0].cyc) >= 2);
      else                  check("rsp_valid_idle", bus.rsp_valid, 1'b0);
      if (hold_q)
        check("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, hold_err, hold_data});
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_extra", bus.rsp_valid, 1'b0);
        else begin
          m_e = exp_q.pop_front();
          check("rsp_data", bus.rsp_data, m_e.data);
          check("rsp_err", bus.rsp_err, m_e.err);
        end
      end
      hold_q    = bus.rsp_valid && !bus.rsp_ready;
      hold_err  = bus.rsp_err;
      hold_data = bus.rsp_data;

      m_sram = '0;
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt++;
        m_a    = bus.req_addr;
        m_err  = (m_a % 4 != 0) || (m_a / 4 >= Words);
        m_e.err  = m_err;
        m_e.data = '0;
        m_e.cyc  = cyc;
        if (!m_err) begin
          m_sram = {1'b1, bus.req_we, !bus.req_we, 30'(m_a / 4), bus.req_data, bus.req_sel};
          if (bus.req_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.req_sel[b]) ref_mem[int'(m_a) + b] = bus.req_data[8*b +: 8];
          end else begin
            m_e.data = {ref_mem[int'(m_a) + 3], ref_mem[int'(m_a) + 2],
                        ref_mem[int'(m_a) + 1], ref_mem[int'(m_a)]};
          end
        end
        exp_q.push_back(m_e);
      end
      check("sram_port", {sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel}, m_sram);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer a request and wait (bounded) until it is taken; req_valid stays high afterwards
  // so consecutive calls give back-to-back requests.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel);
    logic taken;
    int   waited;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_sel   = sel;
    forever begin
      @(negedge clk);
      taken = bus.req_ready;
      step();
      if (taken) break;
      waited++;
      if (waited >= 50) begin
        check("send_accept", bus.req_ready, 1'b1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Release reset and follow the zero-fill word by word.
  task automatic clear_seq();
    rst = 1'b0;
    #1;
    for (int i = 0; i < int'(Words); i++) begin
      check("clear_word",
            {sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel, bus.req_ready, clear_done},
            {3'b110, 30'(i), 32'h0, 4'hF, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    check("clear_done", {clear_done, bus.req_ready, sram_ce}, 3'b110);
    run_phase = 1;
  endtask

  initial begin
    int t0, base;
    logic [31:0] a;
    int r;
    foreach (sram_mem[i]) sram_mem[i] = $urandom;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, sram_ce, sram_we, sram_oe,
           sram_waddr, sram_din, sram_sel, clear_done}, '0);
    clear_seq();

    // 0x1000_0004 lies far beyond the 64-byte memory, so it is an error request;
    // the in-range alias 0x4 carries the write-then-read check.
    bus.rsp_ready = 1'b1;
    send(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    send(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    send(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    send(1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3);
    send(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    send(1'b0, 32'h0000_0002, 32'h0, 4'h0);
    send(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    drain();

    // Sustained rate with rsp_ready held high: one request per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(4 * i), 32'h0, 4'h0);
    check("throughput_cycles", cyc - t0, 8);
    drain();

    // Stalled responses: only three requests can be outstanding, the head stays stable.
    bus.rsp_ready = 1'b0;
    base = acc_cnt;
    send(1'b0, 32'h0, 32'h0, 4'h0);
    send(1'b0, 32'h4, 32'h0, 4'h0);
    send(1'b0, 32'h8, 32'h0, 4'h0);
    bus.req_addr = 32'hC;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_ready", bus.req_ready, 1'b0);
      step();
    end
    check("stall_accepted", acc_cnt - base, 3);
    check("stall_head", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b0, 32'h0});
    bus.rsp_ready = 1'b1;
    send(1'b0, 32'hC, 32'h0, 4'h0);
    drain();

    // Random traffic with random response back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'(64 + $urandom_range(0, 1000));
      else             a = 32'($urandom_range(0, 15) * 4);
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset with two responses pending: they vanish and the zero-fill starts over.
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h4, 32'h0, 4'h0);
    send(1'b0, 32'h8, 32'h0, 4'h0);
    idle(3);
    check("pending_before_reset", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    run_phase = 0;
    #1;
    check("reset_flush",
          {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.req_ready, sram_ce, clear_done}, '0);
    repeat (2) @(posedge clk);
    #1;
    clear_seq();
    bus.rsp_ready = 1'b1;
    send(1'b0, 32'h4, 32'h0, 4'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
